// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg
// Shared definitions for the register-file write-back arbiter.
//   NUM_REQ / REQ_ALU / REQ_LSU : requester count and the bit index of each
//                                 requester in the valid/ready vectors
//   WB_ADDR_W / WB_DATA_W       : default register address and data widths
//   wb_req_t                    : one write-back request {addr, data}
//   slot_state_e                : occupancy of a one-entry holding slot
package regfile_wb_pkg;

  localparam int NUM_REQ   = 2;
  localparam int REQ_ALU   = 0;
  localparam int REQ_LSU   = 1;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/wb_slot.sv
// wb_slot
// One-entry holding register sitting between a write-back requester and the
// arbiter. It accepts a request over valid/ready and releases it when the
// arbiter pops it.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid          requester offers {in_addr, in_data}
//   in_addr, in_data  destination register and write data
//   pop               arbiter granted this slot this cycle
//   ready             slot can take a request at the next edge
//   full              slot holds a write
//   addr, data        stored write
module wb_slot
  import regfile_wb_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              pop,
  output logic              ready,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  slot_state_e state, state_next;
  logic        accept;
  logic        load;

  // A slot being popped this cycle frees up at the same edge, so it may take a
  // new request then; this keeps one write per cycle flowing per requester.
  // Ready is built only from registered state and the grant (itself derived
  // from registered state), so nothing combinational reaches it from valid.
  always_comb begin
    ready      = (state == EMPTY) || pop;
    full       = (state == FULL);
    accept     = in_valid && ready;
    // Writes to r0 are handshaken but dropped: r0 is hard-wired to zero.
    load       = accept && (in_addr != '0);
    state_next = state;
    if (load) begin
      state_next = FULL;
    end else if (pop) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      data <= '0;
    end else if (load) begin
      addr <= in_addr;
      data <= in_data;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between the ALU write-back
// path (requester 0) and the load/store path (requester 1). Each requester
// feeds a one-entry slot; one slot is granted per cycle and its write is
// registered onto the register-file write port. A pending-write mask lets
// decode stall on read-after-write hazards.
// Build option:
//   RR_ARB_EN defined   : round-robin between the slots on contention
//   RR_ARB_EN undefined : fixed priority, the LSU slot wins contention
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-low reset
//   i_req_valid / o_req_ready    per-requester handshake (bit0 ALU, bit1 LSU)
//   i_req_addr0/1, i_req_data0/1 request destination register and data
//   o_rd_addr, o_rd_data         register-file write address and data
//   o_rd_wren                    register-file write enable
//   o_pend_mask                  bit r set while a write to r is in flight
//   o_idle                       both slots empty and no write on the port
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req_valid,
  output logic [NUM_REQ-1:0] o_req_ready,
  input  logic [ADDR_W-1:0]  i_req_addr0,
  input  logic [ADDR_W-1:0]  i_req_addr1,
  input  logic [DATA_W-1:0]  i_req_data0,
  input  logic [DATA_W-1:0]  i_req_data1,
  output logic [ADDR_W-1:0]  o_rd_addr,
  output logic [DATA_W-1:0]  o_rd_data,
  output logic               o_rd_wren,
  output logic [31:0]        o_pend_mask,
  output logic               o_idle
);

  logic              full0, full1;
  logic              grant0, grant1;
  logic              ready0, ready1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;

  wb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_alu (
    .clk      (i_clk),
    .rst_n    (i_rst),
    .in_valid (i_req_valid[REQ_ALU]),
    .in_addr  (i_req_addr0),
    .in_data  (i_req_data0),
    .pop      (grant0),
    .ready    (ready0),
    .full     (full0),
    .addr     (addr0),
    .data     (data0)
  );

  wb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_lsu (
    .clk      (i_clk),
    .rst_n    (i_rst),
    .in_valid (i_req_valid[REQ_LSU]),
    .in_addr  (i_req_addr1),
    .in_data  (i_req_data1),
    .pop      (grant1),
    .ready    (ready1),
    .full     (full1),
    .addr     (addr1),
    .data     (data1)
  );

  always_comb begin
    o_req_ready          = '0;
    o_req_ready[REQ_ALU] = ready0;
    o_req_ready[REQ_LSU] = ready1;
  end

`ifdef RR_ARB_EN
  // rr_ptr names the slot preferred on the next contended cycle.
  logic rr_ptr;

  always_comb begin
    grant0 = full0 && (!full1 || !rr_ptr);
    grant1 = full1 && (!full0 ||  rr_ptr);
  end

  // Only contention moves the pointer; an uncontended grant leaves it alone.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rr_ptr <= 1'b0;
    end else if (full0 && full1) begin
      rr_ptr <= ~rr_ptr;
    end
  end
`else
  // Loads are given the port first because their consumers are typically
  // further down the dependency chain.
  always_comb begin
    grant1 = full1;
    grant0 = full0 && !full1;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_rd_wren <= 1'b0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
    end else begin
      o_rd_wren <= grant0 || grant1;
      if (grant1) begin
        o_rd_addr <= addr1;
        o_rd_data <= data1;
      end else if (grant0) begin
        o_rd_addr <= addr0;
        o_rd_data <= data0;
      end
    end
  end

  // Bit 0 never sets: slots never hold r0, and so the output never carries it.
  always_comb begin
    o_pend_mask = '0;
    for (int r = 1; r < 32; r++) begin
      o_pend_mask[r] = (full0 && (addr0 == ADDR_W'(r))) ||
                       (full1 && (addr1 == ADDR_W'(r))) ||
                       (o_rd_wren && (o_rd_addr == ADDR_W'(r)));
    end
  end

  always_comb begin
    o_idle = !full0 && !full1 && !o_rd_wren;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Directed bench for the write-back arbiter. A table of per-cycle vectors
// covers the single write, r0 discard, contention and same-register cases;
// hand-written sequences cover dual-requester streaming and reset with both
// slots full. Expectations that depend on the arbitration policy follow the
// RR_ARB_EN build option.
module tb_regfile_wb_arbiter;

  import regfile_wb_pkg::*;

  logic        i_clk;
  logic        i_rst;
  logic [1:0]  i_req_valid;
  logic [1:0]  o_req_ready;
  logic [4:0]  i_req_addr0, i_req_addr1;
  logic [31:0] i_req_data0, i_req_data1;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_wren;
  logic [31:0] o_pend_mask;
  logic        o_idle;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  valid;
    wb_req_t     req0;
    wb_req_t     req1;
    logic        exp_wren;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_ready;
    logic [31:0] exp_pend;
    logic        exp_idle;
  } vec_t;

  vec_t vecs[13];

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_addr0 (i_req_addr0),
    .i_req_addr1 (i_req_addr1),
    .i_req_data0 (i_req_data0),
    .i_req_data1 (i_req_data1),
    .o_rd_addr   (o_rd_addr),
    .o_rd_data   (o_rd_data),
    .o_rd_wren   (o_rd_wren),
    .o_pend_mask (o_pend_mask),
    .o_idle      (o_idle)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Hard stop in case a sequence never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  // Move one cycle forward and settle just after the rising edge, where both
  // driving and sampling stay clear of the edge itself.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [4:0] a0, input logic [31:0] d0,
                               input logic [4:0] a1, input logic [31:0] d1);
    i_req_valid = valid;
    i_req_addr0 = a0;
    i_req_data0 = d0;
    i_req_addr1 = a1;
    i_req_data1 = d1;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    check({tag, ".wren"},  64'(o_rd_wren),   64'(v.exp_wren));
    check({tag, ".addr"},  64'(o_rd_addr),   64'(v.exp_addr));
    check({tag, ".data"},  64'(o_rd_data),   64'(v.exp_data));
    check({tag, ".ready"}, 64'(o_req_ready), 64'(v.exp_ready));
    check({tag, ".pend"},  64'(o_pend_mask), 64'(v.exp_pend));
    check({tag, ".idle"},  64'(o_idle),      64'(v.exp_idle));
  endtask

  function automatic vec_t mk(input logic [1:0] valid, input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1,
                              input logic wren, input logic [4:0] ea, input logic [31:0] ed,
                              input logic [1:0] rdy, input logic [31:0] pend, input logic idle);
    vec_t v;
    v.valid     = valid;
    v.req0.addr = a0;
    v.req0.data = d0;
    v.req1.addr = a1;
    v.req1.data = d1;
    v.exp_wren  = wren;
    v.exp_addr  = ea;
    v.exp_data  = ed;
    v.exp_ready = rdy;
    v.exp_pend  = pend;
    v.exp_idle  = idle;
    return v;
  endfunction

  // Streaming scoreboard state.
  int sent[2];
  int got[2];
  int n_writes;
  int prev_src;

  // Every write seen on the port must be the next in-order item of the
  // requester it came from (ALU items tagged 0xA..., LSU items 0xB...).
  task automatic sampleStreamOutput();
    int src;
    if (o_rd_wren) begin
      if (o_rd_data[31:28] == 4'hA) begin
        src = 0;
        check("stream.alu_data", 64'(o_rd_data), 64'(32'hA000_0000 + 32'(got[0])));
        check("stream.alu_addr", 64'(o_rd_addr), 64'd10);
      end else begin
        src = 1;
        check("stream.lsu_data", 64'(o_rd_data), 64'(32'hB000_0000 + 32'(got[1])));
        check("stream.lsu_addr", 64'(o_rd_addr), 64'd20);
      end
      got[src]++;
`ifdef RR_ARB_EN
      if (n_writes > 0) begin
        check("stream.alternate", 64'(src == prev_src), 64'd0);
      end
`endif
      prev_src = src;
      n_writes++;
    end
  endtask

  initial begin
    logic [1:0] rdy;
    logic [1:0] exp_rdy;
    int exp_alu;
    int exp_lsu;

    // Table rows: inputs held across the next edge, outputs checked after it.
    vecs[0]  = mk(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,         2'b11, 32'h0000_0020, 1'b0);
    vecs[1]  = mk(2'b00, 5'd0, 32'h0,         5'd0, 32'h0, 1'b1, 5'd5, 32'hDEAD_BEEF, 2'b11, 32'h0000_0020, 1'b0);
    vecs[2]  = mk(2'b00, 5'd0, 32'h0,         5'd0, 32'h0, 1'b0, 5'd5, 32'hDEAD_BEEF, 2'b11, 32'h0,         1'b1);
    vecs[3]  = mk(2'b01, 5'd0, 32'h1234,      5'd0, 32'h0, 1'b0, 5'd5, 32'hDEAD_BEEF, 2'b11, 32'h0,         1'b1);
    vecs[4]  = mk(2'b00, 5'd0, 32'h0,         5'd0, 32'h0, 1'b0, 5'd5, 32'hDEAD_BEEF, 2'b11, 32'h0,         1'b1);
`ifdef RR_ARB_EN
    vecs[5]  = mk(2'b11, 5'd3, 32'h33, 5'd4, 32'h44, 1'b0, 5'd5, 32'hDEAD_BEEF, 2'b01, 32'h0000_0018, 1'b0);
    vecs[6]  = mk(2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  1'b1, 5'd3, 32'h33,        2'b11, 32'h0000_0018, 1'b0);
    vecs[7]  = mk(2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  1'b1, 5'd4, 32'h44,        2'b11, 32'h0000_0010, 1'b0);
    vecs[8]  = mk(2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  1'b0, 5'd4, 32'h44,        2'b11, 32'h0,         1'b1);
    vecs[9]  = mk(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd4, 32'h44,        2'b10, 32'h0000_0080, 1'b0);
`else
    vecs[5]  = mk(2'b11, 5'd3, 32'h33, 5'd4, 32'h44, 1'b0, 5'd5, 32'hDEAD_BEEF, 2'b10, 32'h0000_0018, 1'b0);
    vecs[6]  = mk(2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  1'b1, 5'd4, 32'h44,        2'b11, 32'h0000_0018, 1'b0);
    vecs[7]  = mk(2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  1'b1, 5'd3, 32'h33,        2'b11, 32'h0000_0008, 1'b0);
    vecs[8]  = mk(2'b00, 5'd0, 32'h0,  5'd0, 32'h0,  1'b0, 5'd3, 32'h33,        2'b11, 32'h0,         1'b1);
    vecs[9]  = mk(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd3, 32'h33,        2'b10, 32'h0000_0080, 1'b0);
`endif
    vecs[10] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h22, 2'b11, 32'h0000_0080, 1'b0);
    vecs[11] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h11, 2'b11, 32'h0000_0080, 1'b0);
    vecs[12] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd7, 32'h11, 2'b11, 32'h0,         1'b1);

    // Reset values while reset is held.
    i_rst = 1'b0;
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #2;
    checkOutput("reset", mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2'b11, 32'h0, 1'b1));
    tick();
    tick();
    i_rst = 1'b1;

    // Single write, r0 discard, contention, same-register ordering.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].req0.addr, vecs[i].req0.data,
                    vecs[i].req1.addr, vecs[i].req1.data);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Both requesters stream for 8 edges; the round-robin pointer is 0 here.
    sent[0]  = 0;
    sent[1]  = 0;
    got[0]   = 0;
    got[1]   = 0;
    n_writes = 0;
    prev_src = -1;
    for (int e = 1; e <= 8; e++) begin
      applyStimulus(2'b11, 5'd10, 32'hA000_0000 + 32'(sent[0]), 5'd20, 32'hB000_0000 + 32'(sent[1]));
      rdy = o_req_ready;
      tick();
      if (rdy[0]) sent[0]++;
      if (rdy[1]) sent[1]++;
      sampleStreamOutput();
`ifdef RR_ARB_EN
      exp_rdy = (e % 2 == 1) ? 2'b01 : 2'b10;
`else
      exp_rdy = 2'b10;
`endif
      check($sformatf("stream.ready%0d", e), 64'(o_req_ready), 64'(exp_rdy));
    end
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    for (int d = 0; d < 10; d++) begin
      tick();
      sampleStreamOutput();
    end
`ifdef RR_ARB_EN
    exp_alu = 5;
    exp_lsu = 4;
`else
    exp_alu = 1;
    exp_lsu = 8;
`endif
    check("stream.alu_sent", 64'(sent[0]), 64'(exp_alu));
    check("stream.lsu_sent", 64'(sent[1]), 64'(exp_lsu));
    check("stream.alu_written", 64'(got[0]), 64'(exp_alu));
    check("stream.lsu_written", 64'(got[1]), 64'(exp_lsu));
    check("stream.idle", 64'(o_idle), 64'd1);

    // Fill both slots and put a write on the port, then reset asynchronously.
    applyStimulus(2'b11, 5'd9, 32'h99, 5'd12, 32'hCC);
    tick();
    tick();
    check("prerst.wren", 64'(o_rd_wren), 64'd1);
    check("prerst.pend", 64'(o_pend_mask), 64'h0000_1200);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #2;
    i_rst = 1'b0;
    #1;
    checkOutput("async_rst", mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2'b11, 32'h0, 1'b1));
    tick();
    tick();
    i_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("postrst%0d.wren", k), 64'(o_rd_wren), 64'd0);
      check($sformatf("postrst%0d.idle", k), 64'(o_idle), 64'd1);
      check($sformatf("postrst%0d.pend", k), 64'(o_pend_mask), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
